muldiv_ctrl: RTL and testbench
==============================

// Module: muldiv_ctrl
// PURPOSE
//  Sequencer for the shared iterative multiply/divide unit beside ex_stage.
//  Accepts MULT/MULTU/DIV/DIVU from EX, runs a radix-2 shift-add/restoring loop,
//  owns HI/LO, and stalls the pipeline (drives stage we low) while HI/LO reads
//  or a new op must wait on a busy unit.
// PARAMETERS
//  WIDTH   32  operand and HI/LO width
//  CNT_W    6  iteration counter width, >= clog2(WIDTH)+1
// PORTS
//  clk        in   1      clock, rising edge
//  reset      in   1      synchronous, active-high
//  start      in   1      EX issues a mul/div op this cycle
//  op         in   2      0=MULT 1=MULTU 2=DIV 3=DIVU
//  data_s     in   WIDTH  rs operand: multiplicand / dividend
//  data_t     in   WIDTH  rt operand: multiplier / divisor
//  hilo_read  in   1      EX holds MFHI/MFLO this cycle
//  hilo_wr    in   2      bit1=MTHI, bit0=MTLO, data from data_s
//  flush      in   1      pipeline flush; aborts the op in flight
//  busy       out  1      FSM not IDLE
//  stall      out  1      freezes IF..EX; ex_stage we = ~stall
//  done       out  1      1-cycle pulse; HI/LO updated this edge
//  hi         out  WIDTH  HI register
//  lo         out  WIDTH  LO register
// BEHAVIOUR
//  Reset: FSM=IDLE; busy=0, stall=0, done=0, hi=0, lo=0, counter=0.
//  FSM IDLE -> RUN -> FIX -> IDLE.
//  IDLE: start=1 latches abs operands (signed ops) or raw operands (unsigned),
//        saves result signs, sets counter=WIDTH, goes to RUN. No stall.
//  RUN: one iteration per cycle, counter decrements; at counter==1 -> FIX.
//   mul: {acc,mq} shifted right by 1, acc += mcand when mq[0]=1.
//   div: remainder shifted left by 1; subtract if no borrow; quotient bit set.
//  FIX: apply sign: mul negates the 2*WIDTH product if signs differ. Signed div
//   negates the quotient if signs differ and takes the remainder sign from the
//   dividend. Writes hi/lo, done=1, -> IDLE.
//  Latency: start at edge N; done high in cycle N+WIDTH+1; new hi/lo visible
//   from N+WIDTH+2. 34 cycles for WIDTH=32.
//  Divide by zero: detected in IDLE on start; skip RUN and go to FIX.
//   Result lo=all-ones, hi=data_s for all 4 ops. done in cycle N+1.
//  stall = busy & (hilo_read | start | hilo_wr!=0). Combinational, no added delay.
//   An op held by stall is re-presented by EX and accepted in the cycle after done.
//  hilo_wr in IDLE: MTHI/MTLO write the next edge. If it coincides with FIX
//   (done), the FIX result wins and the write stalls one cycle.
//  flush=1: any state -> IDLE next edge; hi/lo keep pre-op values; done=0.
//   flush and start in the same cycle: start ignored.
//  reset mid-op: as reset values; the partial result is discarded.
//  Width rules: product 2*WIDTH bits (hi=upper, lo=lower). Quotient and remainder
//   WIDTH bits. Signed overflow (-2^31 / -1): lo=0x80000000, hi=0, no trap.
// STRUCTURE
//  Shared package cpu_pkg: MD_MULT/MD_MULTU/MD_DIV/MD_DIVU op codes and
//  MD_IDLE/MD_RUN/MD_FIX state encodings.
//  One sub-module, muldiv_step: combinational one-iteration datapath
//  (add/shift or compare/subtract). muldiv_ctrl holds the FSM, counter,
//  operand/sign registers and HI/LO.
// TESTING
//  1 MULTU 0xFFFFFFFF*0xFFFFFFFF -> done at +33; hi=0xFFFFFFFE lo=0x00000001.
//  2 MULT -3*7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB. DIV -7/2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF.
//  3 DIVU 100/0 -> done 1 cycle after start; lo=0xFFFFFFFF hi=100; busy high for 1 cycle.
//  4 hilo_read 5 cycles after start -> stall=1 until the done cycle;
//    stall=0 the next cycle with the new lo readable.
//  5 flush at cycle 10 of DIVU 50/5, with hi=lo=0x1234 beforehand -> busy=0 next cycle;
//    hi=lo=0x1234; done never pulses.
//  6 MTLO 0xAA in IDLE -> lo=0xAA next cycle. Back-to-back start while busy ->
//    stall; the second op completes 34 cycles after the first done.

Source files
------------

// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
//  Shared constants for the core: multiply/divide op codes and the state
//  encodings of the multiply/divide sequencer, plus small op-decode helpers.
// ----------------------------------------------------------------------------
package cpu_pkg;

   // Multiply/divide op codes as presented by EX on muldiv_ctrl.op
   localparam logic [1:0] MD_MULT  = 2'd0;
   localparam logic [1:0] MD_MULTU = 2'd1;
   localparam logic [1:0] MD_DIV   = 2'd2;
   localparam logic [1:0] MD_DIVU  = 2'd3;

   // Sequencer state encodings
   localparam logic [1:0] MD_IDLE  = 2'd0;
   localparam logic [1:0] MD_RUN   = 2'd1;
   localparam logic [1:0] MD_FIX   = 2'd2;

   function automatic logic md_is_div(input logic [1:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   function automatic logic md_is_signed(input logic [1:0] op);
      return (op == MD_MULT) || (op == MD_DIV);
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// ----------------------------------------------------------------------------
// muldiv_step
//  Combinational single iteration of the radix-2 multiply/divide loop.
//  Multiply: {acc,mq} >> 1 after acc += opnd when mq[0] is set
//            (acc = running high product, mq = multiplier / low product).
//  Divide:   restoring step on {acc,mq} << 1; subtract opnd from the
//            partial remainder when it fits and shift in a quotient 1
//            (acc = remainder, mq = dividend / quotient).
// Ports
//  is_div    in   1      select divide step (else multiply step)
//  acc       in   WIDTH  high working register
//  mq        in   WIDTH  low working register
//  opnd      in   WIDTH  multiplicand or divisor magnitude
//  acc_next  out  WIDTH  acc after this iteration
//  mq_next   out  WIDTH  mq after this iteration
// ----------------------------------------------------------------------------
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic             is_div,
   input  logic [WIDTH-1:0] acc,
   input  logic [WIDTH-1:0] mq,
   input  logic [WIDTH-1:0] opnd,
   output logic [WIDTH-1:0] acc_next,
   output logic [WIDTH-1:0] mq_next
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   always_comb begin
      // NOTE: every output and temporary gets a default first so no path
      // through this block leaves a value unassigned (which would infer a latch).
      acc_next = acc;
      mq_next  = mq;
      sum      = '0;
      shifted  = '0;
      diff     = '0;
      if (is_div) begin
         // acc < opnd holds between steps, so shifted < 2*opnd and one
         // conditional subtract is enough to keep the remainder below opnd.
         shifted = {acc, mq[WIDTH-1]};
         diff    = shifted - {1'b0, opnd};
         if (shifted >= {1'b0, opnd}) begin
            acc_next = diff[WIDTH-1:0];
            mq_next  = {mq[WIDTH-2:0], 1'b1};
         end else begin
            acc_next = shifted[WIDTH-1:0];
            mq_next  = {mq[WIDTH-2:0], 1'b0};
         end
      end else begin
         // Carry out of the add lands in acc[WIDTH-1] after the shift.
         sum      = {1'b0, acc} + (mq[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
         acc_next = sum[WIDTH:1];
         mq_next  = {sum[0], mq[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// ----------------------------------------------------------------------------
// muldiv_ctrl
//  Sequencer for the shared iterative multiply/divide unit beside ex_stage.
//  Accepts MULT/MULTU/DIV/DIVU, runs WIDTH radix-2 iterations on operand
//  magnitudes, applies result signs in a final FIX cycle, owns HI/LO and
//  stalls the pipeline while HI/LO accesses or a new op wait on a busy unit.
// Ports
//  clk        in   1      clock, rising edge
//  reset      in   1      synchronous, active-high
//  start      in   1      EX issues a mul/div op this cycle
//  op         in   2      0=MULT 1=MULTU 2=DIV 3=DIVU
//  data_s     in   WIDTH  rs: multiplicand / dividend / MTHI-MTLO data
//  data_t     in   WIDTH  rt: multiplier / divisor
//  hilo_read  in   1      EX holds MFHI/MFLO this cycle
//  hilo_wr    in   2      bit1=MTHI, bit0=MTLO
//  flush      in   1      abort op in flight, HI/LO untouched
//  busy       out  1      sequencer not idle
//  stall      out  1      freeze IF..EX
//  done       out  1      HI/LO take the result at the end of this cycle
//  hi         out  WIDTH  HI register
//  lo         out  WIDTH  LO register
// ----------------------------------------------------------------------------
module muldiv_ctrl
   import cpu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] data_s,
   input  logic [WIDTH-1:0] data_t,
   input  logic             hilo_read,
   input  logic [1:0]       hilo_wr,
   input  logic             flush,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] mq;
   logic [WIDTH-1:0] opnd;
   logic             is_div;
   logic             neg_q;     // negate product (mul) or quotient (div)
   logic             neg_r;     // negate remainder (div only)

   logic [WIDTH-1:0]   acc_next;
   logic [WIDTH-1:0]   mq_next;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;
   logic [WIDTH-1:0]   fix_hi;
   logic [WIDTH-1:0]   fix_lo;
   logic               sgn_op;
   logic               div_op;

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x,
                                            input logic sgn);
      return (sgn && x[WIDTH-1]) ? -x : x;
   endfunction

   assign sgn_op = md_is_signed(op);
   assign div_op = md_is_div(op);

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div   (is_div),
      .acc      (acc),
      .mq       (mq),
      .opnd     (opnd),
      .acc_next (acc_next),
      .mq_next  (mq_next)
   );

   // Sign fix-up. Signed overflow (-2^(W-1) / -1) falls out naturally:
   // magnitude quotient 2^(W-1) negated is itself, remainder is 0.
   assign prod     = {acc, mq};
   assign prod_fix = neg_q ? -prod : prod;
   assign quo_fix  = neg_q ? -mq   : mq;
   assign rem_fix  = neg_r ? -acc  : acc;
   assign fix_hi   = is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
   assign fix_lo   = is_div ? quo_fix : prod_fix[WIDTH-1:0];

   assign busy  = (state != MD_IDLE);
   assign stall = busy & (hilo_read | start | (hilo_wr != 2'b00));
   assign done  = (state == MD_FIX) & ~flush;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= MD_IDLE;
         cnt    <= '0;
         acc    <= '0;
         mq     <= '0;
         opnd   <= '0;
         is_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         case (state)
            MD_IDLE: begin
               if (!flush) begin
                  if (hilo_wr[1]) hi <= data_s;
                  if (hilo_wr[0]) lo <= data_s;
                  if (start) begin
                     is_div <= div_op;
                     cnt    <= CNT_W'(WIDTH);
                     if (div_op && (data_t == '0)) begin
                        // Divide by zero: preload the fixed result so FIX
                        // passes it straight through (hi=rs, lo=all ones).
                        acc   <= data_s;
                        mq    <= '1;
                        opnd  <= '0;
                        neg_q <= 1'b0;
                        neg_r <= 1'b0;
                        state <= MD_FIX;
                     end else begin
                        acc   <= '0;
                        neg_q <= sgn_op & (data_s[WIDTH-1] ^ data_t[WIDTH-1]);
                        neg_r <= sgn_op & div_op & data_s[WIDTH-1];
                        state <= MD_RUN;
                        if (div_op) begin
                           mq   <= mag(data_s, sgn_op);
                           opnd <= mag(data_t, sgn_op);
                        end else begin
                           mq   <= mag(data_t, sgn_op);
                           opnd <= mag(data_s, sgn_op);
                        end
                     end
                  end
               end
            end
            MD_RUN: begin
               if (flush) begin
                  state <= MD_IDLE;
               end else begin
                  acc <= acc_next;
                  mq  <= mq_next;
                  cnt <= cnt - 1'b1;
                  if (cnt == CNT_W'(1)) state <= MD_FIX;
               end
            end
            MD_FIX: begin
               // A coincident MTHI/MTLO is stalled and re-presented in IDLE.
               if (!flush) begin
                  hi <= fix_hi;
                  lo <= fix_lo;
               end
               state <= MD_IDLE;
            end
            default: state <= MD_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// ----------------------------------------------------------------------------
// tb_muldiv_ctrl
//  Self-checking bench for muldiv_ctrl (WIDTH=32): directed scenarios plus
//  random ops compared against an arithmetic reference model.
// ----------------------------------------------------------------------------
module tb_muldiv_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] data_s;
   logic [31:0] data_t;
   logic        hilo_read;
   logic [1:0]  hilo_wr;
   logic        flush;
   logic        busy;
   logic        stall;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks = 0;
   int errors = 0;

   muldiv_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .op        (op),
      .data_s    (data_s),
      .data_t    (data_t),
      .hilo_read (hilo_read),
      .hilo_wr   (hilo_wr),
      .flush     (flush),
      .busy      (busy),
      .stall     (stall),
      .done      (done),
      .hi        (hi),
      .lo        (lo)
   );

   always #5 clk = ~clk;

   // Reference: {hi, lo} from plain arithmetic on the architectural rules.
   function automatic logic [63:0] model(input logic [1:0] o,
                                         input logic [31:0] s,
                                         input logic [31:0] t);
      longint a;
      longint b;
      int     q;
      int     r;
      case (o)
         2'd0: begin
            a = longint'($signed(s));
            b = longint'($signed(t));
            return 64'(a * b);
         end
         2'd1: return {32'd0, s} * {32'd0, t};
         2'd2: begin
            if (t == 32'd0) return {s, 32'hFFFF_FFFF};
            if (s == 32'h8000_0000 && t == 32'hFFFF_FFFF)
               return {32'd0, 32'h8000_0000};
            q = $signed(s) / $signed(t);
            r = $signed(s) % $signed(t);
            return {32'(r), 32'(q)};
         end
         default: begin
            if (t == 32'd0) return {s, 32'hFFFF_FFFF};
            return {s % t, s / t};
         end
      endcase
   endfunction

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one op from IDLE, wait for done (bounded), check latency and result.
   task automatic run_op(input logic [1:0] o, input logic [31:0] s,
                         input logic [31:0] t, input string tag);
      logic [63:0] exp;
      int          cyc;
      int          lat;
      exp = model(o, s, t);
      lat = (o[1] && t == 32'd0) ? 1 : 33;
      op = o; data_s = s; data_t = t; start = 1'b1;
      #1;
      check({tag, "_stall_idle"}, 64'(stall), 64'd0);
      tick();
      start = 1'b0;
      cyc = 1;
      while (done !== 1'b1 && cyc < 60) begin
         tick();
         cyc++;
      end
      check({tag, "_latency"}, 64'(cyc), 64'(lat));
      tick();
      check({tag, "_hi"}, 64'(hi), 64'(exp[63:32]));
      check({tag, "_lo"}, 64'(lo), 64'(exp[31:0]));
      check({tag, "_busy_after"}, 64'(busy), 64'd0);
   endtask

   initial begin
      logic [63:0] exp;
      logic [1:0]  ro;
      logic [31:0] rs;
      logic [31:0] rt;
      int          cyc;
      int          pulses;

      reset = 1'b1; start = 1'b0; op = 2'd0; data_s = '0; data_t = '0;
      hilo_read = 1'b0; hilo_wr = 2'b00; flush = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_stall", 64'(stall), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);

      // 1-3: directed arithmetic and divide-by-zero
      run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
      check("multu_max_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
      run_op(2'd0, 32'hFFFF_FFFD, 32'd7, "mult_neg");
      check("mult_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
      run_op(2'd2, 32'hFFFF_FFF9, 32'd2, "div_neg");
      check("div_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op(2'd3, 32'd100, 32'd0, "divu_zero");
      check("divu_zero_const", {hi, lo}, 64'h0000_0064_FFFF_FFFF);
      run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
      run_op(2'd2, 32'hFFFF_FFF0, 32'd0, "div_zero_neg");

      // 4: MFLO held 5 cycles after start stalls through the done cycle
      op = 2'd1; data_s = 32'd123; data_t = 32'd456; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      hilo_read = 1'b1;
      cyc = 0;
      pulses = 0;
      while (cyc < 60) begin
         #1;
         if (stall !== 1'b1) pulses++;
         if (done === 1'b1) break;
         tick();
         cyc++;
      end
      check("rd_stall_held", 64'(pulses), 64'd0);
      check("rd_done_seen", 64'(done), 64'd1);
      tick();
      check("rd_stall_release", 64'(stall), 64'd0);
      check("rd_lo_new", 64'(lo), 64'd56088);
      hilo_read = 1'b0;

      // 5: flush mid-divide keeps prior HI/LO and suppresses done
      hilo_wr = 2'b11; data_s = 32'h1234;
      tick();
      hilo_wr = 2'b00;
      check("mt_both_hi", 64'(hi), 64'h1234);
      check("mt_both_lo", 64'(lo), 64'h1234);
      op = 2'd3; data_s = 32'd50; data_t = 32'd5; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (9) tick();
      flush = 1'b1;
      #1;
      check("flush_done_low", 64'(done), 64'd0);
      tick();
      flush = 1'b0;
      check("flush_busy", 64'(busy), 64'd0);
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         if (done === 1'b1) pulses++;
         tick();
      end
      check("flush_no_done", 64'(pulses), 64'd0);
      check("flush_hi", 64'(hi), 64'h1234);
      check("flush_lo", 64'(lo), 64'h1234);

      // 6: MTLO in IDLE, then back-to-back ops with the second held by stall
      hilo_wr = 2'b01; data_s = 32'hAA;
      tick();
      hilo_wr = 2'b00;
      check("mtlo_lo", 64'(lo), 64'hAA);
      check("mtlo_hi_keep", 64'(hi), 64'h1234);
      op = 2'd1; data_s = 32'd9; data_t = 32'd11; start = 1'b1;
      tick();
      op = 2'd3; data_s = 32'd1000; data_t = 32'd7;
      #1;
      check("b2b_stall", 64'(stall), 64'd1);
      cyc = 0;
      while (done !== 1'b1 && cyc < 60) begin
         tick();
         cyc++;
      end
      check("b2b_first_done", 64'(done), 64'd1);
      tick();
      check("b2b_first_lo", 64'(lo), 64'd99);
      check("b2b_accept_stall", 64'(stall), 64'd0);
      tick();
      start = 1'b0;
      cyc = 2;
      while (done !== 1'b1 && cyc < 80) begin
         tick();
         cyc++;
      end
      check("b2b_gap", 64'(cyc), 64'd34);
      tick();
      check("b2b_second", {hi, lo}, model(2'd3, 32'd1000, 32'd7));

      // MTHI coinciding with done: result wins, write lands one cycle later
      op = 2'd1; data_s = 32'd3; data_t = 32'd4; start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 0;
      while (done !== 1'b1 && cyc < 60) begin
         tick();
         cyc++;
      end
      hilo_wr = 2'b10; data_s = 32'h55;
      #1;
      check("mthi_fix_stall", 64'(stall), 64'd1);
      tick();
      check("mthi_fix_result", {hi, lo}, 64'd12);
      check("mthi_idle_stall", 64'(stall), 64'd0);
      tick();
      hilo_wr = 2'b00;
      check("mthi_late_hi", 64'(hi), 64'h55);

      // Reset mid-op discards the partial result
      op = 2'd0; data_s = 32'd77; data_t = 32'd88; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_hilo", {hi, lo}, 64'd0);
      check("midrst_done", 64'(done), 64'd0);

      // Random ops against the reference model
      for (int i = 0; i < 30; i++) begin
         ro = 2'($urandom_range(0, 3));
         rs = $urandom();
         rt = $urandom();
         case ($urandom_range(0, 5))
            0: rt = 32'd0;
            1: rs = 32'h8000_0000;
            2: rt = 32'($urandom_range(1, 15));
            default: ;
         endcase
         exp = model(ro, rs, rt);
         run_op(ro, rs, rt, $sformatf("rnd%0d_op%0d", i, ro));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
